// File: rtl/gamma_cycle_sequencer_if.sv
// Result channel of the gamma cycle sequencer: first-spike time plus spike flag
// under a valid/ready handshake.
interface gamma_cycle_sequencer_if #(
  parameter int TW = 4
);
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_time;
  logic          res_spiked;

  modport master (output res_valid, output res_time, output res_spiked, input res_ready);
  modport slave  (input res_valid, input res_time, input res_spiked, output res_ready);
endinterface

// File: rtl/gamma_cycle_sequencer.sv
// Gamma cycle sequencer for race-logic datapaths: reset phase, timing window,
// first-spike capture and per-cycle result reporting.
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int RST_CYCLES        = 1,
  parameter int COUNT_WIDTH       = 16,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] num_cycles,
  input  logic                   q_in,
  output logic                   gamma_rst,
  output logic                   window_open,
  output logic [TW-1:0]          cycle_time,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  gamma_cycle_sequencer_if.master res
);

  typedef enum logic [1:0] {IDLE, RESET, RUN} state_t;

  localparam logic [TW-1:0] LAST_T   = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] NO_SPIKE = TW'(GAMMA_CYCLE_WIDTH - RST_CYCLES);

  state_t                 state;
  logic [TW-1:0]          t;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   stop_pend;
  logic                   cap_flag;
  logic [TW-1:0]          cap_time;

  // Outputs are computed for the cycle that follows each edge, so every
  // output stays a flop. remaining == 0 during a run means free-run mode.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state          <= IDLE;
      t              <= '0;
      remaining      <= '0;
      stop_pend      <= 1'b0;
      cap_flag       <= 1'b0;
      cap_time       <= '0;
      gamma_rst      <= 1'b0;
      window_open    <= 1'b0;
      cycle_time     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      res.res_valid  <= 1'b0;
      res.res_time   <= '0;
      res.res_spiked <= 1'b0;
    end else begin
      done <= 1'b0;
      if (res.res_valid && res.res_ready)
        res.res_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RESET;
            t         <= '0;
            remaining <= num_cycles;
            overrun   <= 1'b0;
            stop_pend <= 1'b0;
            cap_flag  <= 1'b0;
            busy      <= 1'b1;
            gamma_rst <= 1'b1;
          end
        end

        RESET: begin
          if (stop)
            stop_pend <= 1'b1;
          cap_flag <= 1'b0;
          t        <= t + TW'(1);
          if (t == RST_LAST) begin
            state       <= RUN;
            gamma_rst   <= 1'b0;
            window_open <= 1'b1;
            cycle_time  <= '0;
          end
        end

        RUN: begin
          if (stop)
            stop_pend <= 1'b1;
          if (q_in && !cap_flag) begin
            cap_flag <= 1'b1;
            cap_time <= cycle_time;
          end
          if (t == LAST_T) begin
            // A spike on the final window cycle is folded straight into the result.
            res.res_valid  <= 1'b1;
            res.res_spiked <= cap_flag | q_in;
            res.res_time   <= cap_flag ? cap_time : (q_in ? cycle_time : NO_SPIKE);
            if (res.res_valid && !res.res_ready)
              overrun <= 1'b1;
            cap_flag    <= 1'b0;
            window_open <= 1'b0;
            cycle_time  <= '0;
            t           <= '0;
            if (remaining != '0)
              remaining <= remaining - COUNT_WIDTH'(1);
            if (stop_pend || stop || remaining == COUNT_WIDTH'(1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state     <= RESET;
              gamma_rst <= 1'b1;
            end
          end else begin
            t          <= t + TW'(1);
            cycle_time <= cycle_time + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Directed bench for gamma_cycle_sequencer with GAMMA_CYCLE_WIDTH=16, RST_CYCLES=1.
module tb_gamma_cycle_sequencer;

  localparam int GW  = 16;
  localparam int RST = 1;
  localparam int CW  = 16;
  localparam int TW  = 4;

  logic          aclk = 1'b0;
  logic          grst;
  logic          start;
  logic          stop;
  logic [CW-1:0] num_cycles;
  logic          q_in;
  logic          gamma_rst;
  logic          window_open;
  logic [TW-1:0] cycle_time;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  gamma_cycle_sequencer_if #(.TW(TW)) rif ();

  gamma_cycle_sequencer #(
    .GAMMA_CYCLE_WIDTH(GW),
    .RST_CYCLES(RST),
    .COUNT_WIDTH(CW),
    .TW(TW)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .start(start),
    .stop(stop),
    .num_cycles(num_cycles),
    .q_in(q_in),
    .gamma_rst(gamma_rst),
    .window_open(window_open),
    .cycle_time(cycle_time),
    .busy(busy),
    .done(done),
    .overrun(overrun),
    .res(rif)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives a start pulse; returns at the negedge of the first reset-phase cycle.
  task automatic do_start(input int n);
    start      = 1'b1;
    num_cycles = CW'(n);
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    grst = 1'b1; start = 1'b0; stop = 1'b0; num_cycles = '0; q_in = 1'b0;
    rif.res_ready = 1'b0;
    repeat (3) @(negedge aclk);
    outs = {gamma_rst, window_open, cycle_time, busy, done, overrun,
            rif.res_valid, rif.res_time, rif.res_spiked};
    checks++;
    if (outs !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected all zero", outs);
    end
    grst = 1'b0;
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || gamma_rst !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_stop: got busy=%b gamma_rst=%b expected 0 0", busy, gamma_rst);
    end
  endtask

  task automatic test_single_spike();
    do_start(1);
    checks++;
    if (gamma_rst !== 1'b1 || busy !== 1'b1 || window_open !== 1'b0 || cycle_time !== '0) begin
      errors++; $display("[TB] FAIL single_rst_phase: got rst=%b busy=%b win=%b ct=%0d expected 1 1 0 0",
                         gamma_rst, busy, window_open, cycle_time);
    end
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      checks++;
      if (window_open !== 1'b1 || gamma_rst !== 1'b0 || cycle_time !== TW'(j)) begin
        errors++; $display("[TB] FAIL single_window: got win=%b rst=%b ct=%0d expected 1 0 %0d",
                           window_open, gamma_rst, cycle_time, j);
      end
      q_in = (j >= 5);
    end
    @(negedge aclk);
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_time !== 4'd5 || rif.res_spiked !== 1'b1) begin
      errors++; $display("[TB] FAIL single_result: got v=%b t=%0d s=%b expected 1 5 1",
                         rif.res_valid, rif.res_time, rif.res_spiked);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || window_open !== 1'b0 || gamma_rst !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done: got done=%b busy=%b win=%b rst=%b expected 1 0 0 0",
                         done, busy, window_open, gamma_rst);
    end
    q_in = 1'b0;
    rif.res_ready = 1'b1;
    @(negedge aclk);
    rif.res_ready = 1'b0;
    checks++;
    if (rif.res_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL single_accept: got v=%b done=%b expected 0 0", rif.res_valid, done);
    end
  endtask

  task automatic test_no_spike();
    do_start(1);
    q_in = 1'b1;
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      q_in = 1'b0;
    end
    @(negedge aclk);
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_time !== 4'd15 || rif.res_spiked !== 1'b0) begin
      errors++; $display("[TB] FAIL no_spike: got v=%b t=%0d s=%b expected 1 15 0",
                         rif.res_valid, rif.res_time, rif.res_spiked);
    end
    rif.res_ready = 1'b1;
    @(negedge aclk);
    rif.res_ready = 1'b0;
  endtask

  task automatic test_edge_times();
    do_start(1);
    q_in = 1'b1;
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      q_in = (j == 0);
    end
    @(negedge aclk);
    checks++;
    if (rif.res_time !== 4'd0 || rif.res_spiked !== 1'b1) begin
      errors++; $display("[TB] FAIL edge_first: got t=%0d s=%b expected 0 1", rif.res_time, rif.res_spiked);
    end
    rif.res_ready = 1'b1;
    @(negedge aclk);
    rif.res_ready = 1'b0;
    do_start(1);
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      q_in = (j == 14);
    end
    @(negedge aclk);
    q_in = 1'b0;
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_time !== 4'd14 || rif.res_spiked !== 1'b1) begin
      errors++; $display("[TB] FAIL edge_last: got v=%b t=%0d s=%b expected 1 14 1",
                         rif.res_valid, rif.res_time, rif.res_spiked);
    end
    rif.res_ready = 1'b1;
    @(negedge aclk);
    rif.res_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int spk [3] = '{2, 7, 9};
    int ovr [3] = '{0, 1, 1};
    rif.res_ready = 1'b0;
    do_start(3);
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < GW - RST; j++) begin
        @(negedge aclk);
        q_in = (j == spk[g]);
      end
      @(negedge aclk);
      q_in = 1'b0;
      checks++;
      if (rif.res_valid !== 1'b1 || rif.res_time !== TW'(spk[g]) || overrun !== ovr[g][0]) begin
        errors++; $display("[TB] FAIL overrun_g%0d: got v=%b t=%0d ovr=%b expected 1 %0d %0d",
                           g, rif.res_valid, rif.res_time, overrun, spk[g], ovr[g]);
      end
      checks++;
      if (g < 2 && (gamma_rst !== 1'b1 || busy !== 1'b1)) begin
        errors++; $display("[TB] FAIL overrun_b2b%0d: got rst=%b busy=%b expected 1 1", g, gamma_rst, busy);
      end else if (g == 2 && (done !== 1'b1 || busy !== 1'b0)) begin
        errors++; $display("[TB] FAIL overrun_done: got done=%b busy=%b expected 1 0", done, busy);
      end
    end
    rif.res_ready = 1'b1;
    @(negedge aclk);
    rif.res_ready = 1'b0;
    checks++;
    if (rif.res_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_accept: got v=%b ovr=%b expected 0 1", rif.res_valid, overrun);
    end
  endtask

  task automatic test_free_run_stop();
    time stamp [4];
    rif.res_ready = 1'b1;
    do_start(0);
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < GW - RST; j++) begin
        @(negedge aclk);
        q_in  = (j == g + 3);
        start = (g == 1 && j == 4);
        stop  = (g == 3 && j == 7);
        num_cycles = CW'(1);
      end
      @(negedge aclk);
      q_in = 1'b0; start = 1'b0; stop = 1'b0;
      stamp[g] = $time;
      checks++;
      if (rif.res_valid !== 1'b1 || rif.res_time !== TW'(g + 3) || overrun !== 1'b0) begin
        errors++; $display("[TB] FAIL free_g%0d: got v=%b t=%0d ovr=%b expected 1 %0d 0",
                           g, rif.res_valid, rif.res_time, overrun, g + 3);
      end
      checks++;
      if (done !== (g == 3) || busy !== (g != 3)) begin
        errors++; $display("[TB] FAIL free_state%0d: got done=%b busy=%b expected %0d %0d",
                           g, done, busy, g == 3, g != 3);
      end
      if (g > 0) begin
        checks++;
        if (stamp[g] - stamp[g-1] !== 160) begin
          errors++; $display("[TB] FAIL free_spacing%0d: got %0t expected 160", g, stamp[g] - stamp[g-1]);
        end
      end
    end
    @(negedge aclk);
    rif.res_ready = 1'b0;
    checks++;
    if (rif.res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL free_after: got v=%b done=%b busy=%b expected 0 0 0",
                         rif.res_valid, done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [14:0] outs;
    rif.res_ready = 1'b0;
    do_start(2);
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      q_in = (j == 3);
    end
    @(negedge aclk);
    q_in = 1'b0;
    repeat (4) @(negedge aclk);
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_time !== 4'd3 || window_open !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_pre: got v=%b t=%0d win=%b expected 1 3 1",
                         rif.res_valid, rif.res_time, window_open);
    end
    grst = 1'b1;
    #1;
    outs = {gamma_rst, window_open, cycle_time, busy, done, overrun,
            rif.res_valid, rif.res_time, rif.res_spiked};
    checks++;
    if (outs !== '0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got %b expected all zero", outs);
    end
    @(negedge aclk);
    grst = 1'b0;
    @(negedge aclk);
    do_start(1);
    for (int j = 0; j < GW - RST; j++) begin
      @(negedge aclk);
      checks++;
      if (cycle_time !== TW'(j) || window_open !== 1'b1) begin
        errors++; $display("[TB] FAIL midrst_window: got ct=%0d win=%b expected %0d 1", cycle_time, window_open, j);
      end
      q_in = (j >= 5);
    end
    @(negedge aclk);
    q_in = 1'b0;
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_time !== 4'd5 || rif.res_spiked !== 1'b1 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_result: got v=%b t=%0d s=%b done=%b expected 1 5 1 1",
                         rif.res_valid, rif.res_time, rif.res_spiked, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_no_spike();
    test_edge_times();
    test_overrun();
    test_free_run_stop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_cycle_sequencer.md
Name: gamma_cycle_sequencer

Overview:
- Sequences gamma cycles for race-logic comparator datapaths such as the ≤ primitive.
- Each gamma cycle opens with a gamma-cycle reset phase that drives the datapath `rst`, then opens a timing window and publishes `cycle_time` to the spike generators.
- During the window it captures the first-spike time of the datapath output.
- The per-cycle result goes out through a valid/ready handshake; runs are a fixed number of gamma cycles or free-run until stopped.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, total aclk cycles per gamma cycle (reset phase + window).
- RST_CYCLES, 1, leading aclk cycles of each gamma cycle with gamma_rst high; legal range 1..GAMMA_CYCLE_WIDTH-1.
- COUNT_WIDTH, 16, width of num_cycles and the remaining-cycle counter.
- TW, $clog2(GAMMA_CYCLE_WIDTH), derived; width of cycle_time and res_time.

Ports:
- aclk  in  1  clock.
- grst  in  1  global reset, asynchronous, active-high.
- start  in  1  one-cycle run request; honoured only in IDLE.
- stop  in  1  graceful stop request; honoured in RESET/RUN.
- num_cycles  in  COUNT_WIDTH  gamma cycles to run, sampled with start; 0 = free-run.
- q_in  in  1  datapath output (the ≤ primitive's q), aclk-synchronous level.
- gamma_rst  out  1  datapath gamma-cycle reset (drives the primitive's rst).
- window_open  out  1  high during the window phase.
- cycle_time  out  TW  time step within the window, 0 outside it.
- busy  out  1  high in RESET/RUN.
- done  out  1  one-cycle pulse on return to IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_time  out  TW  first-spike time, or GAMMA_CYCLE_WIDTH-RST_CYCLES if no spike.
- res_spiked  out  1  q_in was seen high in the window.
- overrun  out  1  sticky; an unconsumed result was overwritten.

Behaviour:
- Reset state (grst high, async): state IDLE; all outputs 0; internal counters 0; capture flag 0.
- All outputs are registered.
- FSM states: IDLE, RESET, RUN. Internal counter t runs 0..GAMMA_CYCLE_WIDTH-1.
- IDLE → RESET:
  - Triggered by start sampled high at edge k.
  - Loads remaining = num_cycles; clears overrun; t = 0.
  - From cycle k+1: busy = 1, gamma_rst = 1.
- RESET:
  - Lasts RST_CYCLES cycles with gamma_rst = 1, window_open = 0, cycle_time = 0.
  - Capture flag is cleared; q_in is ignored.
  - Then → RUN.
- RUN:
  - Lasts GAMMA_CYCLE_WIDTH-RST_CYCLES cycles with window_open = 1, gamma_rst = 0.
  - cycle_time = t-RST_CYCLES, counting 0,1,2…
  - On the first RUN cycle with q_in = 1 and the capture flag clear: latch cycle_time into the capture register and set the flag.
  - Later q_in activity is ignored.
- End of gamma cycle (last RUN cycle, t = GAMMA_CYCLE_WIDTH-1):
  - On the next cycle, res_time and res_spiked are loaded and res_valid = 1.
  - If nothing was captured: res_time = GAMMA_CYCLE_WIDTH-RST_CYCLES ("infinity"), res_spiked = 0.
  - A spike on the last window cycle counts.
- Result handshake:
  - res_valid stays high and the payload stays stable until res_ready is sampled high with res_valid high; res_valid then clears on the next cycle.
  - New result while res_valid = 1 and res_ready = 0: payload is overwritten and overrun is set (sticky until the next accepted start or grst).
  - New result in the same cycle that res_ready accepts the old one: load the new result, no overrun.
- Continuation after each gamma cycle:
  - remaining decrements if nonzero mode.
  - If stop is pending, or the count reaches 0 in counted mode: → IDLE; busy = 0, gamma_rst = 0, done pulses for 1 cycle, coincident with res_valid rising.
  - Otherwise → RESET with t = 0, back-to-back with no idle gap.
  - Latency: start at edge k → first res_valid at cycle k+GAMMA_CYCLE_WIDTH+1; subsequent results every GAMMA_CYCLE_WIDTH cycles.
- Stop handling:
  - stop is latched as pending in RESET/RUN; the current gamma cycle completes and reports.
  - stop in IDLE is ignored.
- start while busy is ignored.
- grst mid-operation: immediate return to reset state; any pending result is discarded.

Test Plan:
- Single spike: GW=16, RST=1; start, num_cycles=1; q_in rises at cycle_time 5 and stays high.
  → gamma_rst high 1 cycle; window cycle_time 0..14; res_time=5, res_spiked=1; done pulses; busy falls.
- No spike: same setup, q_in held 0; q_in=1 only during the reset phase.
  → res_time=15, res_spiked=0; reset-phase activity is ignored.
- Edge times: q_in high at window cycle 0 → res_time=0; spike only at cycle_time 14 → res_time=14, res_spiked=1.
- Overrun: num_cycles=3, res_ready held 0, spikes at times 2, 7, 9.
  → overrun=1 after the second result; final payload res_time=9; first res_ready pulse clears res_valid.
- Free-run with stop: num_cycles=0; stop asserted mid-window in the 4th gamma cycle.
  → 4 results delivered back-to-back 16 cycles apart; done after the 4th; start during the run is ignored.
- Reset mid-run: grst asserted during RUN with res_valid=1.
  → all outputs 0 immediately; a new start behaves as in the single-spike test.
